serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial unsigned adder. Two WIDTH-bit operands are accepted through a
// valid/ready handshake, added one bit per clock (LSB first) with a single
// registered carry, and the WIDTH-bit sum plus carry-out are offered through
// a second valid/ready handshake. This trades WIDTH cycles of latency for a
// datapath that is only one full adder wide.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - synchronous, active-high reset (wins over any handshake)
//   in_valid   - operands a/b are valid this cycle
//   in_ready   - block can accept operands (high only while idle)
//   a, b       - unsigned addends, sampled only on the accept edge
//   out_valid  - sum/carry_out are valid (high only while done)
//   out_ready  - consumer accepts the result
//   sum        - (a + b) mod 2^WIDTH
//   carry_out  - bit WIDTH of a + b
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // The counter must be able to represent WIDTH itself so that the final
    // increment on the last RUN edge never wraps back to zero.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_s;
    logic             ha1_c;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    // One full-adder bit built from two half adders and an OR. The first
    // half adder combines the two operand LSBs, the second folds in the
    // carry; either half adder generating a carry produces the next carry.
    always_comb begin
        ha0_s  = a_sr[0] ^ b_sr[0];
        ha0_c  = a_sr[0] & b_sr[0];
        ha1_s  = ha0_s ^ c;
        ha1_c  = ha0_s & c;
        c_next = ha0_c | ha1_c;
    end

    // The sum register fills from the top: after WIDTH shifts the first
    // computed bit (the LSB) has travelled down to bit 0. Written as a shift
    // plus a single-bit overwrite so that WIDTH = 1 needs no special case.
    always_comb begin
        sum_next            = sum_sr >> 1;
        sum_next[WIDTH-1]   = ha1_s;
    end

    // Handshake outputs are decoded from state alone, so there is no
    // combinational path from in_valid or out_ready to either of them.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        sum       = sum_sr;
        carry_out = c;
    end

    // Main sequencer. IDLE loads the operands and clears the carry and bit
    // counter; RUN consumes one operand bit per edge and leaves after the
    // edge that processes bit WIDTH-1; DONE holds every register untouched
    // until the consumer takes the result, so stalls cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    c      <= c_next;
                    sum_sr <= sum_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). Expected results come
// from plain integer addition of the operands the bench itself chose, never
// from the DUT. Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int cmpCount = 0;
    int errCount = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait somewhere never completes.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one edge and check the post-reset outputs.
    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_sum", 32'(sum), 0);
        checkOutput("rst_carry", 32'(carry_out), 0);
    endtask

    // Run one addition end to end. Must be called 1 ns after an edge with
    // the DUT idle. stall = cycles to hold out_ready low once out_valid is
    // seen; holdReady keeps out_ready high throughout (back-to-back mode);
    // noise drives in_valid with a = b = 1 during RUN; detail enables the
    // per-cycle in_ready / latency / stall stability checks.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input int stall, input bit holdReady,
                                 input bit noise, input bit detail);
        logic [WIDTH:0] expected;
        int             cycles;
        bit             runReadyLow;
        bit             stallStable;
        expected = {1'b0, ta} + {1'b0, tb};
        if (detail) checkOutput("accept_in_ready", 32'(in_ready), 1);
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        out_ready = holdReady;
        tick();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cycles      = 0;
        runReadyLow = 1'b1;
        while (!out_valid && cycles < 4 * WIDTH) begin
            if (in_ready !== 1'b0) runReadyLow = 1'b0;
            if (noise) begin
                in_valid = 1'b1;
                a        = 1;
                b        = 1;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("out_valid_seen", 32'(out_valid), 1);
        if (detail) begin
            checkOutput("latency", 32'(cycles), WIDTH);
            checkOutput("run_in_ready_low", 32'(runReadyLow), 1);
        end
        checkOutput("sum", 32'(sum), 32'(expected[WIDTH-1:0]));
        checkOutput("carry_out", 32'(carry_out), 32'(expected[WIDTH]));
        stallStable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                sum !== expected[WIDTH-1:0] || carry_out !== expected[WIDTH])
                stallStable = 1'b0;
        end
        if (stall > 0) checkOutput("stall_stable", 32'(stallStable), 1);
        out_ready = 1'b1;
        tick();
        if (!holdReady) out_ready = 1'b0;
        if (detail) begin
            checkOutput("post_hs_in_ready", 32'(in_ready), 1);
            checkOutput("post_hs_out_valid", 32'(out_valid), 0);
        end
    endtask

    // Test sequence.
    initial begin
        bit quiet;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        $display("[TB] starting serial_adder bench");
        doReset();

        applyStimulus(8'd3, 8'd5, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd255, 8'd1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd255, 8'd255, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd0, 8'd0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd170, 8'd85, 5, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd100, 8'd27, 0, 1'b0, 1'b1, 1'b1);

        // Reset during the 4th RUN cycle discards the operation.
        a        = 8'd77;
        b        = 8'd99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        doReset();
        quiet = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
            tick();
        end
        checkOutput("no_spurious_valid", 32'(quiet), 1);
        applyStimulus(8'd200, 8'd100, 0, 1'b0, 1'b0, 1'b1);

        // Back-to-back random traffic with out_ready tied high.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                          0, 1'b1, 1'b0, 1'b0);
        end
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
